// File: rtl/fetch_realign_queue_pkg.sv
// Shared types for the fetch realign queue.
// Straddle/RVC support is selected by CVA6_FRQ_RVC_EN.
package fetch_queue_pkg;

  localparam int unsigned VLEN = 64;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] target;
  } bp_t;

  typedef struct packed {
    logic            valid;
    logic [63:0]     cause;
    logic [VLEN-1:0] tval;
  } fq_ex_t;

  typedef struct packed {
    logic [VLEN-1:0] address;
    logic [31:0]     instruction;
    bp_t             bp;
    fq_ex_t          ex;
  } fq_entry_t;

  function automatic logic is_compressed(
    input logic [15:0] i_half
  );
    return i_half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_realign_queue_if.sv
// Fetch-word and ID-entry handshakes of the realign queue.
// slave = queue side, master = frontend/ID side.
interface fetch_realign_queue_if;
  import fetch_queue_pkg::*;

  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [31:0]     fetch_data_i;
  logic [VLEN-1:0] fetch_addr_i;
  bp_t             fetch_bp_i;
  fq_ex_t          fetch_ex_i;
  fq_entry_t       fetch_entry_o;
  logic            fetch_entry_valid_o;
  logic            fetch_entry_ready_i;

  modport slave (
    input  fetch_valid_i,
    input  fetch_data_i,
    input  fetch_addr_i,
    input  fetch_bp_i,
    input  fetch_ex_i,
    input  fetch_entry_ready_i,
    output fetch_ready_o,
    output fetch_entry_o,
    output fetch_entry_valid_o
  );

  modport master (
    output fetch_valid_i,
    output fetch_data_i,
    output fetch_addr_i,
    output fetch_bp_i,
    output fetch_ex_i,
    output fetch_entry_ready_i,
    input  fetch_ready_o,
    input  fetch_entry_o,
    input  fetch_entry_valid_o
  );

endinterface

// File: rtl/fetch_realign_queue_realigner.sv
// Splits a fetch word into up to two entries and keeps a straddling
// upper half in the leftover register (CVA6_FRQ_RVC_EN only).
module fetch_realigner
  import fetch_queue_pkg::*;
(
`ifdef CVA6_FRQ_RVC_EN
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
`endif
  input  logic            i_accept,
  input  logic [31:0]     i_data,
  input  logic [VLEN-1:0] i_addr,
  input  bp_t             i_bp,
  input  fq_ex_t          i_ex,
  output fq_entry_t       o_entry0,
  output fq_entry_t       o_entry1,
  output logic            o_valid0,
  output logic            o_valid1
);

`ifdef CVA6_FRQ_RVC_EN

  logic            r_lo_valid;
  logic [15:0]     r_lo_data;
  logic [VLEN-1:0] r_lo_addr;
  bp_t             r_lo_bp;

  logic [15:0]     w_lo_half;
  logic [15:0]     w_up_half;
  logic            w_lo_c;
  logic            w_up_c;
  logic [VLEN-1:0] w_up_addr;
  fq_entry_t       w_up_entry;
  logic            w_load;

  assign w_lo_half = i_data[15:0];
  assign w_up_half = i_data[31:16];
  assign w_lo_c    = is_compressed(w_lo_half);
  assign w_up_c    = is_compressed(w_up_half);
  assign w_up_addr = i_addr + VLEN'(2);

  // Upper half as a standalone compressed entry; it always ends the word.
  always_comb begin
    w_up_entry             = '0;
    w_up_entry.address     = w_up_addr;
    w_up_entry.instruction = {16'h0, w_up_half};
    w_up_entry.bp          = i_bp;
  end

  // Split the accepted word in program order into slot 0 then slot 1.
  always_comb begin
    o_entry0 = '0;
    o_entry1 = '0;
    o_valid0 = 1'b0;
    o_valid1 = 1'b0;
    w_load   = 1'b0;
    if (i_accept) begin
      if (i_ex.valid) begin
        o_valid0         = 1'b1;
        o_entry0.address = r_lo_valid ? r_lo_addr : i_addr;
        o_entry0.bp      = i_bp;
        o_entry0.ex      = i_ex;
      end else if (r_lo_valid) begin
        o_valid0             = 1'b1;
        o_entry0.address     = r_lo_addr;
        o_entry0.instruction = {w_lo_half, r_lo_data};
        o_entry0.bp          = r_lo_bp;
        if (w_up_c) begin
          o_valid1 = 1'b1;
          o_entry1 = w_up_entry;
        end else begin
          w_load = 1'b1;
        end
      end else if (!i_addr[1] && !w_lo_c) begin
        o_valid0             = 1'b1;
        o_entry0.address     = i_addr;
        o_entry0.instruction = i_data;
        o_entry0.bp          = i_bp;
      end else if (!i_addr[1]) begin
        o_valid0             = 1'b1;
        o_entry0.address     = i_addr;
        o_entry0.instruction = {16'h0, w_lo_half};
        if (w_up_c) begin
          o_valid1 = 1'b1;
          o_entry1 = w_up_entry;
        end else begin
          w_load = 1'b1;
        end
      end else begin
        if (w_up_c) begin
          o_valid0 = 1'b1;
          o_entry0 = w_up_entry;
        end else begin
          w_load = 1'b1;
        end
      end
    end
  end

  // Leftover register: every accepted word consumes or replaces it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lo_valid <= 1'b0;
      r_lo_data  <= '0;
      r_lo_addr  <= '0;
      r_lo_bp    <= '0;
    end else if (flush_i) begin
      r_lo_valid <= 1'b0;
    end else if (i_accept) begin
      r_lo_valid <= w_load;
      if (w_load) begin
        r_lo_data <= w_up_half;
        r_lo_addr <= w_up_addr;
        r_lo_bp   <= i_bp;
      end
    end
  end

  // A pending half must be continued by the next sequential word.
  a_contig: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (i_accept && r_lo_valid) |-> (i_addr == r_lo_addr + VLEN'(2))
  );

`else

  // One 32-bit entry per word; exceptions carry no instruction bits.
  always_comb begin
    o_entry0             = '0;
    o_entry1             = '0;
    o_valid0             = i_accept;
    o_valid1             = 1'b0;
    o_entry0.address     = i_addr;
    o_entry0.instruction = i_ex.valid ? 32'h0 : i_data;
    o_entry0.bp          = i_bp;
    o_entry0.ex          = i_ex;
  end

`endif

endmodule

// File: rtl/fetch_realign_queue.sv
// Fetch realign queue: realigner feeding a registered FIFO towards ID.
// Define CVA6_FRQ_RVC_EN to enable compressed splitting and straddles.
module fetch_realign_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = fetch_queue_pkg::VLEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  fetch_realign_queue_if.slave   fq,
  output logic [$clog2(DEPTH):0] occupancy_o
);
  import fetch_queue_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef CVA6_FRQ_RVC_EN
  localparam int unsigned FREE_MIN = 2;
`else
  localparam int unsigned FREE_MIN = 1;
`endif
  localparam logic [CW-1:0] C_LIM = CW'(DEPTH - FREE_MIN);

  fq_entry_t       r_mem [DEPTH];
  fq_entry_t       r_last;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;

  logic [VLEN-1:0] w_addr;
  logic            w_accept;
  logic            w_pop;
  logic            w_v0;
  logic            w_v1;
  fq_entry_t       w_e0;
  fq_entry_t       w_e1;
  logic [CW-1:0]   w_push_n;

  assign w_addr   = fq.fetch_addr_i;
  assign w_accept = fq.fetch_valid_i && fq.fetch_ready_o;
  assign w_pop    = fq.fetch_entry_valid_o
                 && fq.fetch_entry_ready_i
                 && !flush_i;
  assign w_push_n = CW'(w_v0) + CW'(w_v1);

  // Ready uses registered occupancy only, never the ID handshake.
  assign fq.fetch_ready_o = !rst_i && !flush_i && (r_cnt <= C_LIM);
  assign fq.fetch_entry_valid_o = (r_cnt != '0);
  assign fq.fetch_entry_o = (r_cnt != '0) ? r_mem[r_rptr] : r_last;
  assign occupancy_o = r_cnt;

  fetch_realigner u_realigner (
`ifdef CVA6_FRQ_RVC_EN
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
`endif
    .i_accept (w_accept),
    .i_data   (fq.fetch_data_i),
    .i_addr   (w_addr),
    .i_bp     (fq.fetch_bp_i),
    .i_ex     (fq.fetch_ex_i),
    .o_entry0 (w_e0),
    .o_entry1 (w_e1),
    .o_valid0 (w_v0),
    .o_valid1 (w_v1)
  );

  // Storage write: slot 0 then slot 1 at consecutive pointers.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (w_v0) r_mem[r_wptr] <= w_e0;
      if (w_v1) r_mem[r_wptr + PW'(1)] <= w_e1;
    end
  end

  // Pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_wptr <= r_wptr + w_push_n[PW-1:0];
      r_rptr <= r_rptr + PW'(w_pop);
      r_cnt  <= r_cnt + w_push_n - CW'(w_pop);
    end
  end

  // Remember the last popped head so an empty queue holds its output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= r_mem[r_rptr];
    end
  end

`ifndef CVA6_FRQ_RVC_EN
  // Without RVC support every fetch word must be word aligned.
  a_aligned: assert property (
    @(posedge clk_i) disable iff (rst_i)
    w_accept |-> !w_addr[1]
  );
`endif

endmodule

// File: tb/tb_fetch_realign_queue.sv
// Scoreboard bench for fetch_realign_queue (DEPTH=4).
// Expectations follow CVA6_FRQ_RVC_EN when it is defined.
module tb_fetch_realign_queue;
  import fetch_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] occ;

  fetch_realign_queue_if fq ();

  fetch_realign_queue #(
    .DEPTH (4),
    .VLEN  (64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .fq          (fq),
    .occupancy_o (occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [31:0] i;
    logic        bp;
    logic        ex;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic exp_e(input logic [63:0] a, input logic [31:0] i,
                       input logic bp, input logic ex);
    exp_t e;
    e.a  = a;
    e.i  = i;
    e.bp = bp;
    e.ex = ex;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: compare each consumed head against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && fq.fetch_entry_valid_o &&
        fq.fetch_entry_ready_i) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected entry: got addr %0h want none",
                 fq.fetch_entry_o.address);
      end else begin
        e = q.pop_front();
        if (fq.fetch_entry_o.address !== e.a ||
            fq.fetch_entry_o.instruction !== e.i ||
            fq.fetch_entry_o.bp.valid !== e.bp ||
            fq.fetch_entry_o.ex.valid !== e.ex ||
            fq.fetch_entry_o.ex.cause !== {63'h0, e.ex}) begin
          n_err++;
          $display("FAIL entry: got a=%0h i=%0h bp=%0b ex=%0b want a=%0h i=%0h bp=%0b ex=%0b",
                   fq.fetch_entry_o.address,
                   fq.fetch_entry_o.instruction,
                   fq.fetch_entry_o.bp.valid,
                   fq.fetch_entry_o.ex.valid,
                   e.a, e.i, e.bp, e.ex);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic [63:0] a,
                       input logic bpv, input logic exv);
    fq.fetch_valid_i         = 1'b1;
    fq.fetch_data_i          = d;
    fq.fetch_addr_i          = a;
    fq.fetch_bp_i.valid      = bpv;
    fq.fetch_bp_i.target     = 64'hB0;
    fq.fetch_ex_i.valid      = exv;
    fq.fetch_ex_i.cause      = {63'h0, exv};
    fq.fetch_ex_i.tval       = a;
  endtask

  task automatic send(input logic [31:0] d, input logic [63:0] a,
                      input logic bpv, input logic exv);
    int t = 0;
    @(posedge clk); #1;
    drive(d, a, bpv, exv);
    @(negedge clk);
    while (!fq.fetch_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!fq.fetch_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL send timeout: ready got 0 want 1 at %0h", a);
    end
    @(posedge clk); #1;
    fq.fetch_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    fq.fetch_entry_ready_i = 1'b1;
    while ((occ != 0 || q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain occ", 64'(occ), 64'd0);
    chk("drain sb", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    fq.fetch_entry_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    fq.fetch_entry_ready_i = 1'b0;
    drive(32'h0, 64'h0, 1'b0, 1'b0);
    fq.fetch_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid", 64'(fq.fetch_entry_valid_o), 64'd0);
    chk("rst occ", 64'(occ), 64'd0);
    chk("rst ready", 64'(fq.fetch_ready_o), 64'd0);
    chk("rst entry", 64'(|fq.fetch_entry_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single 32-bit word, visible one cycle after accept
    @(posedge clk); #1;
    exp_e(64'h1000, 32'h00010413, 1'b0, 1'b0);
    drive(32'h00010413, 64'h1000, 1'b0, 1'b0);
    @(negedge clk);
    chk("empty ready", 64'(fq.fetch_ready_o), 64'd1);
    chk("no fallthru", 64'(fq.fetch_entry_valid_o), 64'd0);
    @(posedge clk); #1;
    fq.fetch_valid_i = 1'b0;
    chk("occ one", 64'(occ), 64'd1);
    chk("head valid", 64'(fq.fetch_entry_valid_o), 64'd1);
    chk("head addr", fq.fetch_entry_o.address, 64'h1000);
    chk("head instr", 64'(fq.fetch_entry_o.instruction),
        64'h00010413);

    // fill until ready drops, then pop one
`ifdef CVA6_FRQ_RVC_EN
    exp_e(64'h2000, 32'h4501, 1'b0, 1'b0);
    exp_e(64'h2002, 32'h4501, 1'b0, 1'b0);
    send(32'h45014501, 64'h2000, 1'b0, 1'b0);
    chk("dual push occ", 64'(occ), 64'd3);
    chk("full ready", 64'(fq.fetch_ready_o), 64'd0);
`else
    exp_e(64'h2000, 32'h45014501, 1'b0, 1'b0);
    send(32'h45014501, 64'h2000, 1'b0, 1'b0);
    exp_e(64'h2004, 32'h11111111, 1'b0, 1'b0);
    send(32'h11111111, 64'h2004, 1'b0, 1'b0);
    exp_e(64'h2008, 32'h22222222, 1'b0, 1'b0);
    send(32'h22222222, 64'h2008, 1'b0, 1'b0);
    chk("fill occ", 64'(occ), 64'd4);
    chk("full ready", 64'(fq.fetch_ready_o), 64'd0);
`endif
    fq.fetch_entry_ready_i = 1'b1;
    @(posedge clk); #1;
    fq.fetch_entry_ready_i = 1'b0;
`ifdef CVA6_FRQ_RVC_EN
    chk("pop occ", 64'(occ), 64'd2);
`else
    chk("pop occ", 64'(occ), 64'd3);
`endif
    chk("ready back", 64'(fq.fetch_ready_o), 64'd1);
    drain();

    // straddling instructions and held prediction
`ifdef CVA6_FRQ_RVC_EN
    exp_e(64'h3000, 32'h4501, 1'b0, 1'b0);
    exp_e(64'h3002, 32'h00010413, 1'b0, 1'b0);
    exp_e(64'h3006, 32'h0000, 1'b1, 1'b0);
    exp_e(64'h3008, 32'h4501, 1'b0, 1'b0);
    exp_e(64'h300A, 32'h00010413, 1'b1, 1'b0);
    exp_e(64'h300E, 32'h4501, 1'b0, 1'b0);
`else
    exp_e(64'h3000, 32'h04134501, 1'b0, 1'b0);
    exp_e(64'h3004, 32'h00000001, 1'b1, 1'b0);
    exp_e(64'h3008, 32'h04134501, 1'b1, 1'b0);
    exp_e(64'h300C, 32'h45010001, 1'b0, 1'b0);
`endif
    send(32'h04134501, 64'h3000, 1'b0, 1'b0);
    send(32'h00000001, 64'h3004, 1'b1, 1'b0);
    send(32'h04134501, 64'h3008, 1'b1, 1'b0);
    send(32'h45010001, 64'h300C, 1'b0, 1'b0);
    drain();

    // exceptions, with and without a pending half
`ifdef CVA6_FRQ_RVC_EN
    exp_e(64'h4002, 32'h0, 1'b0, 1'b1);
    send(32'h00010413, 64'h4002, 1'b0, 1'b1);
    exp_e(64'h5000, 32'h4501, 1'b0, 1'b0);
    exp_e(64'h5002, 32'h0, 1'b0, 1'b1);
    exp_e(64'h5008, 32'h00010413, 1'b0, 1'b0);
    send(32'h04134501, 64'h5000, 1'b0, 1'b0);
    send(32'h12345678, 64'h5004, 1'b0, 1'b1);
    send(32'h00010413, 64'h5008, 1'b0, 1'b0);
    exp_e(64'h6004, 32'h4501, 1'b1, 1'b0);
    send(32'h45010413, 64'h6002, 1'b1, 1'b0);
`else
    exp_e(64'h4000, 32'h0, 1'b0, 1'b1);
    send(32'h00010413, 64'h4000, 1'b0, 1'b1);
    exp_e(64'h5000, 32'h00010413, 1'b0, 1'b0);
    send(32'h00010413, 64'h5000, 1'b0, 1'b0);
`endif
    drain();

    // push and pop in the same cycle
    exp_e(64'h7000, 32'h00010413, 1'b0, 1'b0);
    send(32'h00010413, 64'h7000, 1'b0, 1'b0);
    exp_e(64'h7004, 32'h00020413, 1'b0, 1'b0);
    fq.fetch_entry_ready_i = 1'b1;
    drive(32'h00020413, 64'h7004, 1'b0, 1'b0);
    @(negedge clk);
    chk("pp ready", 64'(fq.fetch_ready_o), 64'd1);
    @(posedge clk); #1;
    fq.fetch_valid_i = 1'b0;
    fq.fetch_entry_ready_i = 1'b0;
    chk("pp occ", 64'(occ), 64'd1);
    chk("pp head", fq.fetch_entry_o.address, 64'h7004);
    drain();

    // flush with three queued entries (and a pending half)
`ifdef CVA6_FRQ_RVC_EN
    send(32'h45014501, 64'h8000, 1'b0, 1'b0);
    send(32'h04134501, 64'h8004, 1'b0, 1'b0);
`else
    send(32'h00010413, 64'h8000, 1'b0, 1'b0);
    send(32'h00010413, 64'h8004, 1'b0, 1'b0);
    send(32'h00010413, 64'h8008, 1'b0, 1'b0);
`endif
    chk("pre flush occ", 64'(occ), 64'd3);
    flush = 1'b1;
    @(negedge clk);
    chk("flush ready", 64'(fq.fetch_ready_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush valid", 64'(fq.fetch_entry_valid_o), 64'd0);
    chk("flush occ", 64'(occ), 64'd0);
    exp_e(64'h9000, 32'h00010413, 1'b0, 1'b0);
    send(32'h00010413, 64'h9000, 1'b0, 1'b0);
    chk("post flush occ", 64'(occ), 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_realign_queue.md
Name: fetch_realign_queue

Overview:
- Sits between the frontend fetch unit and the decode/ID stage.
- Accepts 32-bit aligned fetch words and splits them into 16-bit (compressed) and 32-bit instructions, re-joining instructions that straddle two words.
- Buffers the results in a small FIFO and presents them to ID over the fetch_entry valid/ready handshake. The queue head drives ID directly.

Parameters:
- DEPTH, 4, number of fetch_entry slots in the FIFO; power of two, minimum 2.
- VLEN, 64, width of the instruction address.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  drop all queued and partial state
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  fetch word accepted when valid && ready
- fetch_data_i  in  32  fetch word
- fetch_addr_i  in  VLEN  word address; bit1=1 means the lower half is not part of the stream (jump target)
- fetch_bp_i  in  bp_t  branch prediction for the last instruction that ends in this word
- fetch_ex_i  in  fq_ex_t  fetch exception (valid, cause, tval)
- fetch_entry_o  out  fq_entry_t  {address, instruction[31:0], bp, ex}
- fetch_entry_valid_o  out  1  queue head valid
- fetch_entry_ready_i  in  1  ID consumes head when valid && ready
- occupancy_o  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Reset: FIFO empty, leftover register invalid. fetch_entry_valid_o=0, fetch_entry_o='0, occupancy_o=0, fetch_ready_o=0 while rst_i is high.
- fetch_ready_o = !flush_i && (free slots >= 2). Free slots are computed from registered occupancy only; a same-cycle pop is not counted. This keeps the path combinationally independent of fetch_entry_ready_i.
- Compressed test: instr[1:0] != 2'b11.
- Split rules for an accepted word W at address A, with leftover L (16 bits at address LA):
  - L valid: emit {W[15:0], L} at LA, then process W[31:16] at A+2.
  - L invalid and A[1]=0: process W[15:0] at A. If it is 32-bit, emit W at A and stop. If it is compressed, emit it zero-extended, then process W[31:16] at A+2.
  - A[1]=1: W[15:0] is ignored; process W[31:16] at A+2.
  - Processing the upper half: if compressed, emit it; if 32-bit, store it in L (LA=A+2) and emit nothing for it.
- Each word produces 0, 1 or 2 entries, written into the FIFO in program order in the accept cycle.
- bp is attached only to the last entry emitted from W. Other entries carry bp='0.
- If L is set by a word carrying bp.valid, the predicted bp is held with L and attached to the joined instruction.
- Exception (fetch_ex_i.valid): exactly one entry is emitted, with address = (L valid ? LA : A), instruction='0 and the ex fields. L is cleared.
- Latency: an entry written in cycle N is visible on fetch_entry_o at N+1. The head is a registered FIFO read; there is no fall-through.
- Push and pop in the same cycle are legal at any occupancy; occupancy_o = old + pushes − pop.
- Pointers wrap modulo DEPTH. FIFO full ⇒ fetch_ready_o=0. FIFO empty ⇒ fetch_entry_valid_o=0, and fetch_entry_o holds its last value.
- flush_i: next cycle the FIFO is empty and L is invalid. Any push or pop in the flush cycle is discarded. Flush has priority over everything except rst_i.
- Reset asserted mid-operation: immediate return to the reset state, with no partial entries.
- Contract: with L valid, the next accepted word must satisfy A == LA+2 unless a flush occurred in between. A simulation assertion flags any violation.

Optional Feature:
- Macro: CVA6_FRQ_RVC_EN.
- Defined: compressed splitting, the leftover register and straddle joining behave as above.
- Undefined: each word yields exactly one 32-bit entry at A. The leftover logic is removed. fetch_ready_o requires only 1 free slot. A[1]=1 is illegal and flagged by an assertion. bp is attached to that single entry.

Decomposition:
- Shared package fetch_queue_pkg holds:
  - bp_t {valid, target[VLEN-1:0]}
  - fq_ex_t {valid, cause[63:0], tval[VLEN-1:0]}
  - fq_entry_t
  - function is_compressed(logic[15:0])
- One sub-module, fetch_realigner: combinational split plus the leftover register. It outputs up to two entries and their valid bits.
- FIFO storage, pointers and occupancy live in the top module.

Test Plan:
- Word 0x00010413 at 0x1000, no L → one entry {0x1000, 0x00010413}; occupancy 1, visible the next cycle.
- Word 0x45014501 at 0x2000 → entries {0x2000, 0x4501} and {0x2002, 0x4501}; two pushes in one cycle.
- Straddle: word 0x04134501 at 0x3000 then 0x00000001 at 0x3004 → {0x3000, 0x4501} first; then {0x3002, 0x00010413}, then {0x3006, 0x0000}.
- Word at 0x4002 with fetch_ex_i.valid=1 (cause 1) → single entry {addr 0x4002, instr 0, ex.valid 1}; L cleared.
- Fill to DEPTH=4 with fetch_entry_ready_i=0 → fetch_ready_o=0 at occupancy 3; pop one → ready returns the following cycle.
- flush_i while occupancy=3 and L valid → next cycle fetch_entry_valid_o=0, occupancy_o=0; the next word is processed with no join.
